wb_rr_interconnect: RTL and testbench
=====================================

Name: wb_rr_interconnect

Overview:
- Parametrised N-master to 1-slave Wishbone arbiter-multiplexer.
- Generalises the two-port icache/dcache-to-L2 interconnect to NUM_MASTERS ports with configurable bus widths.
- Uses round-robin fairness, registered grant, master-abort handling and an optional watchdog.
- Sits between the L1 caches (plus any added requesters, e.g. a prefetcher) and the L2 Wishbone port.

Parameters:
- NUM_MASTERS, 2, number of requesting master ports (2..8).
- DAT_W, 128, data width (line size).
- ADR_W, 12, address width.
- SEL_W, 16, byte-select width (DAT_W/8).
- TIMEOUT, 64, watchdog limit in cycles; used only with WB_RR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_cyc  in  NUM_MASTERS  per-master CYC
- m_stb  in  NUM_MASTERS  per-master STB
- m_we  in  NUM_MASTERS  per-master WE
- m_sel  in  NUM_MASTERS*SEL_W  packed SEL; master i occupies slice [i*SEL_W +: SEL_W]
- m_adr  in  NUM_MASTERS*ADR_W  packed ADR
- m_dat_m  in  NUM_MASTERS*DAT_W  packed write data
- m_ack  out  NUM_MASTERS  per-master ACK
- m_rty  out  NUM_MASTERS  per-master RTY
- m_dat_s  out  NUM_MASTERS*DAT_W  packed read data
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_sel  out  SEL_W  to slave
- s_adr  out  ADR_W  to slave
- s_dat_m  out  DAT_W  write data to slave
- s_ack, s_rty  in  1 each  from slave
- s_dat_s  in  DAT_W  read data from slave
- grant_valid  out  1  a master currently owns the slave
- grant_idx  out  $clog2(NUM_MASTERS)  index of the owning master

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, rst.
- Request definition: req[i] = m_cyc[i] & m_stb[i].
- State machine has two states: IDLE and GRANT.
  - State, grant_idx and round-robin pointer rr_ptr are registers.
- Reset: state=IDLE, grant_idx=0, rr_ptr=0, grant_valid=0.
  - Every s_* control output is 0; s_sel, s_adr and s_dat_m are 0.
  - All m_ack=0, m_rty=0, m_dat_s=0.
  - Reset mid-transaction drops the grant in the same edge; no ACK is forwarded afterwards.
- IDLE:
  - Nothing is routed; every slave-side output is 0.
  - If any req, choose the first requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - Register it into grant_idx and go to GRANT.
  - Latency: request seen at edge k, slave sees CYC/STB from cycle k+1.
- GRANT:
  - Combinationally route master grant_idx's cyc/stb/we/sel/adr/dat_m to s_*.
  - Route s_ack to m_ack[grant_idx], s_rty to m_rty[grant_idx], and s_dat_s to m_dat_s[grant_idx].
  - Non-granted masters see ack=0, rty=0, dat_s=0.
  - grant_valid=1.
- Completion: s_ack or s_rty while in GRANT.
  - Set rr_ptr = (grant_idx+1) mod NUM_MASTERS and go to IDLE.
  - This gives one dead cycle between consecutive grants, matching the stall cycle of the current design.
- Abort: m_cyc[grant_idx] deasserts in GRANT without s_ack/s_rty.
  - s_cyc drops immediately (routed); next edge goes to IDLE and advances rr_ptr.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
  - Every master waiting is granted within NUM_MASTERS transactions.
- Requests from non-granted masters are held off; their m_ack stays 0 until granted.
- Pointer wrap: rr_ptr = NUM_MASTERS-1 then +1 gives 0.
- s_ack arriving in IDLE is ignored.

Optional Feature:
- Macro: WB_RR_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle without s_ack/s_rty.
  - When the count reaches TIMEOUT-1 without completion, the arbiter asserts m_rty[grant_idx] for that one cycle.
  - In that same cycle it forces s_cyc=s_stb=0, then goes to IDLE with rr_ptr advanced.
  - Counter width is $clog2(TIMEOUT+1); counter resets to 0.
- Undefined: no counter; GRANT waits indefinitely for s_ack, s_rty or abort.

Test Plan:
- Reset then single request: NUM_MASTERS=2, only master 1 requests a read at addr 0x040.
  - Required: s_adr=0x040 one cycle after the request.
  - Slave ACK with data 0xDEAD..: m_ack[1]=1 and m_dat_s[1] equal to that data in the same cycle.
  - After completion: IDLE and rr_ptr=0.
- Simultaneous request: masters 0 and 1 both request, rr_ptr=0.
  - Required: master 0 granted first, then exactly one dead cycle, then master 1 granted.
  - m_ack[1] never asserted during master 0's transaction.
- Fairness: NUM_MASTERS=4, all four hold requests continuously.
  - Required grant order 0,1,2,3,0; each slave transaction ACKs after 2 cycles.
  - rr_ptr wraps from 3 to 0.
- Abort: master 2 drops m_cyc mid-grant with no ACK.
  - Required: s_cyc=0 in the same cycle and IDLE next cycle.
  - A late s_ack is ignored and no m_ack is pulsed.
- Retry passthrough: slave asserts s_rty for master 0.
  - Required: m_rty[0]=1 for one cycle, m_ack[0]=0, and the next grant goes to master 1 if it is requesting.
- Watchdog (WB_RR_TIMEOUT_EN, TIMEOUT=8): the slave never answers.
  - Required: m_rty[grant_idx] pulses on the 8th GRANT cycle, s_cyc=0 in that cycle, then IDLE.
  - Same bench without the macro: the grant is still held at cycle 100.

Source files
------------

// File: rtl/wb_rr_interconnect.sv
// N-master to 1-slave Wishbone arbiter/mux with round-robin grant and master-abort handling.
// Optional slave watchdog enabled by defining WB_RR_TIMEOUT_EN.
module wb_rr_interconnect #(
  parameter int NUM_MASTERS = 2,
  parameter int DAT_W       = 128,
  parameter int ADR_W       = 12,
  parameter int SEL_W       = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*SEL_W-1:0]     m_sel,
  input  logic [NUM_MASTERS*ADR_W-1:0]     m_adr,
  input  logic [NUM_MASTERS*DAT_W-1:0]     m_dat_m,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_rty,
  output logic [NUM_MASTERS*DAT_W-1:0]     m_dat_s,
  output logic                             s_cyc,
  output logic                             s_stb,
  output logic                             s_we,
  output logic [SEL_W-1:0]                 s_sel,
  output logic [ADR_W-1:0]                 s_adr,
  output logic [DAT_W-1:0]                 s_dat_m,
  input  logic                             s_ack,
  input  logic                             s_rty,
  input  logic [DAT_W-1:0]                 s_dat_s,
  output logic                             grant_valid,
  output logic [$clog2(NUM_MASTERS)-1:0]   grant_idx
);

  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] req;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic [IW-1:0]          nxt_ptr;
  logic                   wd_fire;
  int                     scan_j;

  assign req       = m_cyc & m_stb;
  assign nxt_ptr   = (grant_q == IW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_idx = grant_q;

  // Scan from the far end so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    scan_j   = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan_j = int'(rr_ptr_q) + k;
      if (scan_j >= NUM_MASTERS) scan_j = scan_j - NUM_MASTERS;
      if (req[scan_j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(scan_j);
      end
    end
  end

`ifdef WB_RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_fire  = 1'b0;
    if (state_q == IDLE) begin
      wd_cnt_d = '0;
    end else if (!(s_ack || s_rty)) begin
      wd_fire  = (wd_cnt_q == CW'(TIMEOUT - 1));
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  // Without the watchdog a grant is held until the slave answers or the master aborts.
  assign wd_fire = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    s_we        = 1'b0;
    s_sel       = '0;
    s_adr       = '0;
    s_dat_m     = '0;
    m_ack       = '0;
    m_rty       = '0;
    m_dat_s     = '0;
    grant_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_valid                   = 1'b1;
        s_cyc                         = m_cyc[grant_q] & ~wd_fire;
        s_stb                         = m_stb[grant_q] & ~wd_fire;
        s_we                          = m_we[grant_q];
        s_sel                         = m_sel[grant_q*SEL_W +: SEL_W];
        s_adr                         = m_adr[grant_q*ADR_W +: ADR_W];
        s_dat_m                       = m_dat_m[grant_q*DAT_W +: DAT_W];
        m_ack[grant_q]                = s_ack;
        m_rty[grant_q]                = s_rty | wd_fire;
        m_dat_s[grant_q*DAT_W +: DAT_W] = s_dat_s;
        // Completion, retry, master abort and watchdog expiry all release the slave.
        if (s_ack || s_rty || !m_cyc[grant_q] || wd_fire) begin
          state_d  = IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Bench for wb_rr_interconnect: directed scenarios plus random traffic against a transaction-level model.
// Watchdog expectations follow WB_RR_TIMEOUT_EN.
module tb_wb_rr_interconnect;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 4;
  localparam int TO = 8;
`ifdef WB_RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_rty;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_m, m_dat_s;
  logic            s_cyc, s_stb, s_we, s_ack, s_rty;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_m, s_dat_s;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  always #5 clk = ~clk;

  wb_rr_interconnect #(
    .NUM_MASTERS(N), .DAT_W(DW), .ADR_W(AW), .SEL_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
    .m_dat_m(m_dat_m), .m_ack(m_ack), .m_rty(m_rty), .m_dat_s(m_dat_s),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_m(s_dat_m), .s_ack(s_ack), .s_rty(s_rty), .s_dat_s(s_dat_s),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: who owns the slave (-1 none), where the next search starts,
  // how long the current owner has waited, and the last index granted.
  int owner, ptr, wd, gi_m;

  logic            snap_gv, snap_scyc;
  logic [1:0]      snap_gi;
  logic [AW-1:0]   snap_sadr;
  logic [N-1:0]    snap_ack, snap_rty;
  logic [N*DW-1:0] snap_dats;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int i, input bit req, input bit we, input logic [AW-1:0] adr);
    m_cyc[i] = req;
    m_stb[i] = req;
    m_we[i]  = we;
    m_adr[i*AW +: AW] = adr;
    m_sel[i*SW +: SW] = '1;
    m_dat_m[i*DW +: DW] = $urandom;
  endtask

  // One clock: compare outputs with the model, then advance the model across the edge.
  task automatic cycle();
    logic [N-1:0]    req;
    logic [N-1:0]    e_ack, e_rty;
    logic [N*DW-1:0] e_dat;
    bit              own, fire;
    int              o, n_owner, n_ptr, n_wd, n_gi, cand;
    #1;
    req  = m_cyc & m_stb;
    own  = (owner >= 0);
    o    = own ? owner : 0;
    fire = TO_EN && own && (wd == TO - 1) && !s_ack && !s_rty;
    e_ack = '0;
    e_rty = '0;
    e_dat = '0;
    if (own) begin
      e_ack[o] = s_ack;
      e_rty[o] = s_rty | fire;
      e_dat[o*DW +: DW] = s_dat_s;
    end
    check("s_ctl", {s_cyc, s_stb, s_we},
          own ? {m_cyc[o] & ~fire, m_stb[o] & ~fire, m_we[o]} : 3'b000);
    check("s_sel", s_sel, own ? m_sel[o*SW +: SW] : '0);
    check("s_adr", s_adr, own ? m_adr[o*AW +: AW] : '0);
    check("s_dat_m", s_dat_m, own ? m_dat_m[o*DW +: DW] : '0);
    check("m_ack", m_ack, e_ack);
    check("m_rty", m_rty, e_rty);
    check("m_dat_s", m_dat_s, e_dat);
    check("grant", {grant_valid, grant_idx}, {own, 2'(gi_m)});

    n_owner = owner; n_ptr = ptr; n_wd = wd; n_gi = gi_m;
    if (rst) begin
      n_owner = -1; n_ptr = 0; n_wd = 0; n_gi = 0;
    end else if (!own) begin
      for (int k = 0; k < N; k++) begin
        cand = (ptr + k) % N;
        if (n_owner < 0 && req[cand]) n_owner = cand;
      end
      if (n_owner >= 0) begin
        n_gi = n_owner;
        n_wd = 0;
      end
    end else if (s_ack || s_rty || !m_cyc[o] || fire) begin
      n_owner = -1;
      n_ptr   = (o + 1) % N;
    end else begin
      n_wd = wd + 1;
    end

    snap_gv   = grant_valid;
    snap_gi   = grant_idx;
    snap_scyc = s_cyc;
    snap_sadr = s_adr;
    snap_ack  = m_ack;
    snap_rty  = m_rty;
    snap_dats = m_dat_s;

    @(posedge clk);
    owner = n_owner; ptr = n_ptr; wd = n_wd; gi_m = n_gi;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int gcnt, fired, gc;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_m = '0;
    s_ack = 1'b0; s_rty = 1'b0; s_dat_s = '0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    owner = -1; ptr = 0; wd = 0; gi_m = 0;
    cycle();
    rst = 1'b0;
    check("rst_gv", snap_gv, 1'b0);

    // Single read from master 1.
    set_m(1, 1'b1, 1'b0, 12'h040);
    cycle();
    check("t1_idle", snap_scyc, 1'b0);
    cycle();
    check("t1_adr", snap_sadr, 12'h040);
    check("t1_gi", {snap_gv, snap_gi}, 3'b101);
    s_ack = 1'b1; s_dat_s = 32'hDEADBEEF;
    cycle();
    check("t1_ack", snap_ack, 4'b0010);
    check("t1_dat", snap_dats[1*DW +: DW], 32'hDEADBEEF);
    s_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 12'h0);
    cycle();
    check("t1_done", snap_gv, 1'b0);

    // Masters 0 and 1 together; search starts at 2 so 0 is the first found.
    set_m(0, 1'b1, 1'b1, 12'h100);
    set_m(1, 1'b1, 1'b0, 12'h104);
    cycle();
    cycle();
    check("sim_g0", {snap_gv, snap_gi}, 3'b100);
    s_ack = 1'b1;
    cycle();
    check("sim_ack0", snap_ack, 4'b0001);
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 12'h0);
    cycle();
    check("sim_dead", snap_gv, 1'b0);
    cycle();
    check("sim_g1", {snap_gv, snap_gi}, 3'b101);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 12'h0);
    cycle();

    // Fairness from a fresh reset: all four request, slave acks on each grant's 2nd cycle.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, 12'(16 * i));
    gcnt = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      if (grant_valid) gcnt++;
      else gcnt = 0;
      if (grant_valid && gcnt == 1) order.push_back(int'(grant_idx));
      s_ack = (gcnt == 2);
      cycle();
    end
    s_ack = 1'b0;
    check("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 12'h0);
    cycle();

    // Master 2 aborts mid-grant; a late ack must not leak through.
    set_m(2, 1'b1, 1'b1, 12'h2A0);
    cycle();
    cycle();
    check("ab_g2", {snap_gv, snap_gi, snap_scyc}, 4'b1101);
    set_m(2, 1'b0, 1'b1, 12'h2A0);
    cycle();
    check("ab_scyc", snap_scyc, 1'b0);
    s_ack = 1'b1;
    cycle();
    check("ab_idle", snap_gv, 1'b0);
    check("ab_noack", snap_ack, 4'b0000);
    s_ack = 1'b0;

    // Retry to master 0 while master 1 waits.
    set_m(0, 1'b1, 1'b0, 12'h300);
    set_m(1, 1'b1, 1'b0, 12'h310);
    cycle();
    cycle();
    check("rt_g0", {snap_gv, snap_gi}, 3'b100);
    s_rty = 1'b1;
    cycle();
    check("rt_rty", snap_rty, 4'b0001);
    check("rt_ack", snap_ack, 4'b0000);
    s_rty = 1'b0;
    set_m(0, 1'b0, 1'b0, 12'h0);
    cycle();
    check("rt_dead", snap_gv, 1'b0);
    cycle();
    check("rt_next", {snap_gv, snap_gi}, 3'b101);
    set_m(1, 1'b0, 1'b0, 12'h0);
    cycle();

    // Silent slave with master 3 requesting.
    set_m(3, 1'b1, 1'b0, 12'h3F0);
    gc = 0;
`ifdef WB_RR_TIMEOUT_EN
    fired = 0;
    for (int i = 0; i < 40 && fired == 0; i++) begin
      cycle();
      if (snap_gv) gc++;
      if (snap_rty[3]) begin
        fired = gc;
        check("wd_scyc", snap_scyc, 1'b0);
      end
    end
    check("wd_cycle", fired, TO);
    cycle();
    check("wd_idle", snap_gv, 1'b0);
`else
    fired = 0;
    for (int i = 0; i < 101; i++) begin
      cycle();
      if (snap_gv) gc++;
      if (snap_rty != '0) fired++;
    end
    check("wd_hold", {snap_gv, snap_gi}, 3'b111);
    check("wd_gcyc", gc, 100);
    check("wd_norty", fired, 0);
`endif
    set_m(3, 1'b0, 1'b0, 12'h0);
    cycle();
    cycle();

    // Random traffic, aborts, retries and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = m_cyc[i] & ($urandom_range(7) != 0);
        m_we[i]  = 1'($urandom);
        m_sel[i*SW +: SW] = 4'($urandom);
        m_adr[i*AW +: AW] = 12'($urandom);
        m_dat_m[i*DW +: DW] = $urandom;
      end
      s_ack   = ($urandom_range(3) == 0);
      s_rty   = ($urandom_range(15) == 0);
      s_dat_s = $urandom;
      rst     = ($urandom_range(199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
